neuron_mac_stage: RTL and testbench

- Upstream neighbour of the CORDIC activation pipeline (sin/cos stage chain followed by division stage chain).
- Computes one neuron pre-activation z = sum(x_k*w_k) + bias in signed Q4.16.
- Clamps z to the CORDIC convergence range and launches it with the fixed CORDIC start vector.
- Streams features and weights in over a valid/ready handshake and holds the result until it is consumed.

---
 rtl/neuron_mac_stage_pkg.sv | 24 ++
 rtl/neuron_mac_stage_q_round_sat.sv | 46 ++++
 rtl/neuron_mac_stage.sv | 157 +++++++++++++++
 tb/tb_neuron_mac_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_stage_pkg.sv
// Shared Q-format constants and FSM encoding for the neuron MAC stage.
// The stage feeds the CORDIC activation pipeline.
package neuron_mac_stage_pkg;

    localparam int unsigned Q_INTEGRAL_WIDTH = 4;
    localparam int unsigned Q_FRACTION_WIDTH = 16;
    localparam int unsigned DATA_WIDTH       = Q_INTEGRAL_WIDTH + Q_FRACTION_WIDTH;
    localparam int unsigned Q_ACC_WIDTH      = 48;
    localparam int unsigned Q_MAX_INPUTS     = 16;

    localparam logic [DATA_WIDTH-1:0] ONE_Q         = DATA_WIDTH'(1) << Q_FRACTION_WIDTH;
    // Start vector pre-scaled by 1/K so the CORDIC output needs no gain fix-up.
    localparam logic [DATA_WIDTH-1:0] CORDIC_X_INIT = 20'h13521;
    localparam logic [DATA_WIDTH-1:0] Z_LIMIT       = ONE_Q;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDrain,
        StFinal,
        StOutput
    } state_e;

endpackage

// File: rtl/neuron_mac_stage_q_round_sat.sv
// Rounding right shift of a wide accumulator plus bias, followed by a symmetric clamp.
// Purely combinational; the sat flag reports that the clamp was applied.
module q_round_sat
    import neuron_mac_stage_pkg::*;
#(
    parameter int unsigned        DATA_W = DATA_WIDTH,
    parameter int unsigned        FRAC_W = Q_FRACTION_WIDTH,
    parameter int unsigned        ACC_W  = Q_ACC_WIDTH,
    parameter logic [DATA_W-1:0]  LIMIT  = ONE_Q
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_bias,
    output logic [DATA_W-1:0] o_z,
    output logic              o_sat
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] w_pos_lim;
    logic signed [ACC_W-1:0] w_neg_lim;

    assign w_acc      = i_acc;
    // Bias is aligned to the accumulator's 2*FRAC_W fraction before the shift.
    assign w_bias_ext = {{(ACC_W - DATA_W){i_bias[DATA_W-1]}}, i_bias} << FRAC_W;
    assign w_sum      = w_acc + w_bias_ext + HALF;
    assign w_shift    = w_sum >>> FRAC_W;
    assign w_pos_lim  = {{(ACC_W - DATA_W){1'b0}}, LIMIT};
    assign w_neg_lim  = -w_pos_lim;

    always_comb begin
        o_z   = w_shift[DATA_W-1:0];
        o_sat = 1'b0;
        if (w_shift > w_pos_lim) begin
            o_z   = LIMIT;
            o_sat = 1'b1;
        end else if (w_shift < w_neg_lim) begin
            o_z   = w_neg_lim[DATA_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_stage.sv
// Streams feature/weight beats into a signed MAC, adds bias, rounds and clamps the result,
// and presents it with the fixed CORDIC start vector until downstream takes it.
module neuron_mac_stage
    import neuron_mac_stage_pkg::*;
#(
    parameter int unsigned INTEGRAL_WIDTH = Q_INTEGRAL_WIDTH,
    parameter int unsigned FRACTION_WIDTH = Q_FRACTION_WIDTH,
    parameter int unsigned ACC_WIDTH      = Q_ACC_WIDTH,
    parameter int unsigned MAX_INPUTS     = Q_MAX_INPUTS,
    parameter logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] Z_LIMIT = neuron_mac_stage_pkg::Z_LIMIT,
    parameter logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] X_INIT  = CORDIC_X_INIT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     in_last,
    input  logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] x_feat,
    input  logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] w_feat,
    input  logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] bias,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] x_out,
    output logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] y_out,
    output logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] z_out,
    output logic                                     sat,
    output logic                                     len_err
);

    localparam int unsigned    DW       = INTEGRAL_WIDTH + FRACTION_WIDTH;
    localparam int unsigned    PW       = 2 * DW;
    localparam int unsigned    CW       = $clog2(MAX_INPUTS + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_INPUTS - 1);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_armed;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic signed [PW-1:0]   r_prod;
    logic [CW-1:0]          r_cnt;
    logic [DW-1:0]          r_bias;
    logic [DW-1:0]          r_z;
    logic                   r_sat;
    logic                   r_len_err;

    logic signed [DW-1:0]   w_x;
    logic signed [DW-1:0]   w_w;
    logic signed [PW-1:0]   w_prod;
    logic [ACC_WIDTH-1:0]   w_prod_ext;
    logic                   w_accept;
    logic                   w_max_beat;
    logic                   w_done;
    logic                   w_out_fire;
    logic [DW-1:0]          w_z;
    logic                   w_sat;

    assign w_x        = x_feat;
    assign w_w        = w_feat;
    assign w_prod     = w_x * w_w;
    assign w_prod_ext = {{(ACC_WIDTH - PW){r_prod[PW-1]}}, r_prod};

    // r_armed keeps in_ready low until the first clock after reset release.
    assign in_ready   = r_armed && ((r_state == StIdle) || (r_state == StAccum));
    assign w_accept   = in_valid && in_ready;
    assign w_max_beat = (r_cnt == LAST_CNT);
    assign w_done     = w_accept && (in_last || w_max_beat);
    assign out_valid  = (r_state == StOutput);
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_done) begin
                    w_state_next = StDrain;
                end else if (w_accept) begin
                    w_state_next = StAccum;
                end
            end
            StAccum: begin
                if (w_done) begin
                    w_state_next = StDrain;
                end
            end
            StDrain:  w_state_next = StFinal;
            StFinal:  w_state_next = StOutput;
            StOutput: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default:  w_state_next = StIdle;
        endcase
    end

    q_round_sat #(
        .DATA_W (DW),
        .FRAC_W (FRACTION_WIDTH),
        .ACC_W  (ACC_WIDTH),
        .LIMIT  (Z_LIMIT)
    ) u_round_sat (
        .i_acc  (r_acc),
        .i_bias (r_bias),
        .o_z    (w_z),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_armed   <= 1'b0;
            r_acc     <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_bias    <= '0;
            r_z       <= '0;
            r_sat     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_armed   <= 1'b1;
            // A zero product on idle cycles keeps the accumulate step unconditional.
            r_prod    <= w_accept ? w_prod : '0;
            r_len_err <= w_accept && w_max_beat && !in_last;

            if (r_state == StIdle) begin
                r_acc <= '0;
            end else if ((r_state == StAccum) || (r_state == StDrain)) begin
                r_acc <= r_acc + w_prod_ext;
            end

            if (w_out_fire) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_accept && in_last) begin
                r_bias <= bias;
            end else if (w_out_fire) begin
                r_bias <= '0;
            end

            if (r_state == StFinal) begin
                r_z   <= w_z;
                r_sat <= w_sat;
            end
        end
    end

    assign x_out   = out_valid ? X_INIT : '0;
    assign y_out   = '0;
    assign z_out   = out_valid ? r_z : '0;
    assign sat     = out_valid && r_sat;
    assign len_err = r_len_err;

endmodule

// File: tb/tb_neuron_mac_stage.sv
// Directed, table-driven bench for neuron_mac_stage with hand-computed Q4.16 results.
module tb_neuron_mac_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [19:0] x_feat;
    logic [19:0] w_feat;
    logic [19:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] x_out;
    logic [19:0] y_out;
    logic [19:0] z_out;
    logic        sat;
    logic        len_err;

    int n_pass  = 0;
    int n_total = 0;

    neuron_mac_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .x_feat    (x_feat),
        .w_feat    (w_feat),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .sat       (sat),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check20(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [19:0] x, input logic [19:0] w, input logic last,
                             input logic [19:0] b);
        int n = 0;
        in_valid = 1'b1;
        x_feat   = x;
        w_feat   = w;
        in_last  = last;
        bias     = b;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL beat_accept: in_ready stayed %b, expected 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // lat is the cycle index of the first out_valid, counting the accepting cycle as 0.
    task automatic wait_out(output int lat);
        int n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = n;
        if (!out_valid) begin
            n_total++;
            $display("FAIL out_valid_timeout: out_valid stayed %b, expected 1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check1("consume_valid_drop", out_valid, 1'b0);
        check1("consume_ready_back", in_ready, 1'b1);
    endtask

    typedef struct packed {
        logic [19:0] x0;
        logic [19:0] w0;
        logic        two;
        logic [19:0] x1;
        logic [19:0] w1;
        logic [19:0] b;
        logic [19:0] z;
        logic        s;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        int lat;

        //             x0        w0        two   x1        w1        bias      z         sat
        vecs[0]  = '{20'h10000, 20'h08000, 1'b1, 20'h20000, 20'hFC000, 20'h04000, 20'h04000, 1'b0};
        vecs[1]  = '{20'h00001, 20'h08000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'h00001, 1'b0};
        vecs[2]  = '{20'h00001, 20'hF8000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'h00000, 1'b0};
        vecs[3]  = '{20'h70000, 20'h70000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'h10000, 1'b1};
        vecs[4]  = '{20'h70000, 20'h90000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'hF0000, 1'b1};
        vecs[5]  = '{20'h10000, 20'h10000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'h10000, 1'b0};
        vecs[6]  = '{20'h10000, 20'hF0000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'hF0000, 1'b0};
        vecs[7]  = '{20'h10001, 20'h10000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'h10000, 1'b1};
        vecs[8]  = '{20'h00003, 20'h08000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'h00002, 1'b0};
        vecs[9]  = '{20'h00003, 20'hF8000, 1'b0, 20'h0, 20'h0, 20'h00000, 20'hFFFFF, 1'b0};
        vecs[10] = '{20'h00000, 20'h00000, 1'b0, 20'h0, 20'h0, 20'h20000, 20'h10000, 1'b1};
        vecs[11] = '{20'h00000, 20'h00000, 1'b0, 20'h0, 20'h0, 20'hE0000, 20'hF0000, 1'b1};
        vecs[12] = '{20'h30000, 20'h08000, 1'b1, 20'h08000, 20'hF0000, 20'hF8000, 20'h08000, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        x_feat = '0; w_feat = '0; bias = '0;

        repeat (2) @(posedge clk);
        #1;
        check1("reset_in_ready", in_ready, 1'b0);
        check1("reset_out_valid", out_valid, 1'b0);
        check20("reset_x_out", x_out, 20'h0);
        check20("reset_z_out", z_out, 20'h0);
        check1("reset_len_err", len_err, 1'b0);
        rst = 1'b1;
        #1;
        check1("release_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check1("release_ready_rise", in_ready, 1'b1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].two) send_beat(vecs[i].x0, vecs[i].w0, 1'b0, 20'h0);
            send_beat(vecs[i].two ? vecs[i].x1 : vecs[i].x0,
                      vecs[i].two ? vecs[i].w1 : vecs[i].w0, 1'b1, vecs[i].b);
            check1("vec_ready_drain", in_ready, 1'b0);
            wait_out(lat);
            check_int("vec_latency", lat, 3);
            check20("vec_z_out", z_out, vecs[i].z);
            check1("vec_sat", sat, vecs[i].s);
            check20("vec_x_out", x_out, 20'h13521);
            check20("vec_y_out", y_out, 20'h0);
            consume();
        end

        // 16 beats of 1/256 each, no in_last: terminates on count, sums to 1/16.
        for (int i = 0; i < 16; i++) begin
            send_beat(20'h01000, 20'h01000, 1'b0, 20'h0);
            if (i < 15) check1("len_err_early", len_err, 1'b0);
            else        check1("len_err_pulse", len_err, 1'b1);
        end
        check1("len_err_ready_low", in_ready, 1'b0);
        wait_out(lat);
        check_int("len_err_latency", lat, 3);
        check1("len_err_one_cycle", len_err, 1'b0);
        check20("len_err_z_out", z_out, 20'h01000);
        check1("len_err_sat", sat, 1'b0);
        consume();

        // Backpressure: offered beats while holding must not be consumed.
        send_beat(20'h10000, 20'h08000, 1'b0, 20'h0);
        send_beat(20'h20000, 20'hFC000, 1'b1, 20'h04000);
        wait_out(lat);
        in_valid = 1'b1; x_feat = 20'h70000; w_feat = 20'h70000; in_last = 1'b1; bias = 20'h20000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check1("bp_valid_held", out_valid, 1'b1);
            check20("bp_z_stable", z_out, 20'h04000);
            check1("bp_ready_low", in_ready, 1'b0);
        end
        check20("bp_x_stable", x_out, 20'h13521);
        in_valid = 1'b0; in_last = 1'b0;
        consume();
        send_beat(20'h10000, 20'h08000, 1'b1, 20'h0);
        wait_out(lat);
        check20("bp_next_z_out", z_out, 20'h08000);
        check1("bp_next_sat", sat, 1'b0);
        consume();

        // Reset mid-neuron discards the three partial beats.
        for (int i = 0; i < 3; i++) send_beat(20'h10000, 20'h10000, 1'b0, 20'h0);
        rst = 1'b0;
        #1;
        check1("midrst_in_ready", in_ready, 1'b0);
        check1("midrst_out_valid", out_valid, 1'b0);
        check20("midrst_z_out", z_out, 20'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_beat(20'h10000, 20'h10000, 1'b1, 20'h0);
        wait_out(lat);
        check20("midrst_next_z_out", z_out, 20'h10000);
        check1("midrst_next_sat", sat, 1'b0);

        // Reset while holding a saturated result clears outputs immediately.
        consume();
        send_beat(20'h70000, 20'h70000, 1'b1, 20'h0);
        wait_out(lat);
        check1("outrst_sat_before", sat, 1'b1);
        rst = 1'b0;
        #1;
        check1("outrst_out_valid", out_valid, 1'b0);
        check1("outrst_sat", sat, 1'b0);
        check20("outrst_x_out", x_out, 20'h0);
        check20("outrst_z_out", z_out, 20'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
